// File: rtl/taxi_tick_sched.sv
// taxi_tick_sched: trip sequencer and distance/waiting-time tick divider for the taxi fare path
// Ports: clk, rst_n (sync, active-low), start, stop, wheel_pulse -> dist_tick, wait_tick, trip_end, state[1:0]
// Optional TAXI_TICK_CFG_EN adds cfg_we, cfg_sel[1:0], cfg_data[CNT_W-1:0] for runtime divisors (IDLE-only writes)
module taxi_tick_sched #(
  parameter int CNT_W     = 12,
  parameter int DIST_DIV  = 100,
  parameter int WAIT_DIV  = 1000,
  parameter int STALL_LIM = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             wheel_pulse,
`ifdef TAXI_TICK_CFG_EN
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
`endif
  output logic             dist_tick,
  output logic             wait_tick,
  output logic             trip_end,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_WAIT = 2'b10} state_t;
  state_t st;
  logic [CNT_W-1:0] dist_cnt, wait_cnt, stall_cnt;
  logic [CNT_W-1:0] dist_div, wait_div, stall_lim;
  logic dist_hit, wait_hit, stall_hit;
`ifdef TAXI_TICK_CFG_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      dist_div  <= CNT_W'(DIST_DIV);
      wait_div  <= CNT_W'(WAIT_DIV);
      stall_lim <= CNT_W'(STALL_LIM);
    end else if (cfg_we && st == S_IDLE && cfg_data != '0) begin
      if (cfg_sel == 2'd0) dist_div <= cfg_data;
      if (cfg_sel == 2'd1) wait_div <= cfg_data;
      if (cfg_sel == 2'd2) stall_lim <= cfg_data;
    end
`else
  assign dist_div  = CNT_W'(DIST_DIV);
  assign wait_div  = CNT_W'(WAIT_DIV);
  assign stall_lim = CNT_W'(STALL_LIM);
`endif
  assign dist_hit  = dist_cnt == dist_div - CNT_W'(1);
  assign wait_hit  = wait_cnt == wait_div - CNT_W'(1);
  assign stall_hit = stall_cnt == stall_lim - CNT_W'(1);
  assign state     = st;
  always_ff @(posedge clk)
    if (!rst_n) begin
      st        <= S_IDLE;
      dist_cnt  <= '0;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      dist_tick <= 1'b0;
      wait_tick <= 1'b0;
      trip_end  <= 1'b0;
    end else begin
      dist_tick <= 1'b0;
      wait_tick <= 1'b0;
      trip_end  <= 1'b0;
      case (st)
        S_IDLE: begin
          dist_cnt  <= '0;
          wait_cnt  <= '0;
          stall_cnt <= '0;
          if (start && !stop) st <= S_RUN;
        end
        S_RUN, S_WAIT: begin
          // stop wins over every same-cycle event, so a coincident terminal count is dropped
          if (stop) begin
            st        <= S_IDLE;
            trip_end  <= 1'b1;
            dist_cnt  <= '0;
            wait_cnt  <= '0;
            stall_cnt <= '0;
          end else begin
            if (wheel_pulse) begin
              dist_cnt  <= dist_hit ? '0 : dist_cnt + CNT_W'(1);
              dist_tick <= dist_hit;
              stall_cnt <= '0;
              st        <= S_RUN;
            end else if (st == S_RUN) begin
              stall_cnt <= stall_hit ? '0 : stall_cnt + CNT_W'(1);
              if (stall_hit) st <= S_WAIT;
            end
            // waiting time keeps accumulating; wait_cnt is kept across RUN so partial time is not lost
            if (st == S_WAIT) begin
              wait_cnt  <= wait_hit ? '0 : wait_cnt + CNT_W'(1);
              wait_tick <= wait_hit;
            end
          end
        end
        default: begin
          st        <= S_IDLE;
          dist_cnt  <= '0;
          wait_cnt  <= '0;
          stall_cnt <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_taxi_tick_sched.sv
// tb_taxi_tick_sched: directed self-checking bench for taxi_tick_sched with default divisors
module tb_taxi_tick_sched;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, wheel_pulse = 1'b0;
  logic dist_tick, wait_tick, trip_end;
  logic [1:0] state;
`ifdef TAXI_TICK_CFG_EN
  logic cfg_we = 1'b0;
  logic [1:0] cfg_sel = 2'd0;
  logic [11:0] cfg_data = 12'd0;
`endif
  int vec = 0, errs = 0;
  always #5 clk = ~clk;
  taxi_tick_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .wheel_pulse(wheel_pulse),
`ifdef TAXI_TICK_CFG_EN
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
`endif
    .dist_tick(dist_tick), .wait_tick(wait_tick), .trip_end(trip_end), .state(state)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_once(output logic t);
    wheel_pulse = 1'b1;
    step();
    t = dist_tick;
    wheel_pulse = 1'b0;
    step();
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    step();
    step();
    vec++; if (state !== 2'b00) begin errs++; $display("FAIL reset_state got %b want 00", state); end
    vec++; if (dist_tick !== 1'b0) begin errs++; $display("FAIL reset_dist_tick got %b want 0", dist_tick); end
    vec++; if (wait_tick !== 1'b0) begin errs++; $display("FAIL reset_wait_tick got %b want 0", wait_tick); end
    vec++; if (trip_end !== 1'b0) begin errs++; $display("FAIL reset_trip_end got %b want 0", trip_end); end
    start = 1'b0;
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_distance();
    int ticks = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    vec++; if (state !== 2'b01) begin errs++; $display("FAIL start_run got %b want 01", state); end
    for (int p = 1; p <= 250; p++) begin
      wheel_pulse = 1'b1;
      step();
      wheel_pulse = 1'b0;
      vec++; if (dist_tick !== (p == 100 || p == 200)) begin errs++; $display("FAIL dist_tick_p%0d got %b want %b", p, dist_tick, (p == 100 || p == 200)); end
      if (dist_tick) ticks++;
      repeat (9) begin
        step();
        if (dist_tick) ticks++;
      end
    end
    vec++; if (ticks != 2) begin errs++; $display("FAIL dist_tick_count got %0d want 2", ticks); end
    vec++; if (state !== 2'b01) begin errs++; $display("FAIL dist_state got %b want 01", state); end
  endtask
  task automatic test_stall_wait();
    int ticks = 0, early = 0;
    logic t;
    wheel_pulse = 1'b1;
    step();
    wheel_pulse = 1'b0;
    repeat (499) step();
    vec++; if (state !== 2'b01) begin errs++; $display("FAIL stall_499 got %b want 01", state); end
    step();
    vec++; if (state !== 2'b10) begin errs++; $display("FAIL stall_500 got %b want 10", state); end
    for (int j = 1; j <= 3000; j++) begin
      step();
      if (wait_tick) ticks++;
      if (j == 1000) begin
        vec++; if (wait_tick !== 1'b1) begin errs++; $display("FAIL wait_tick_1000 got %b want 1", wait_tick); end
      end
    end
    vec++; if (ticks != 3) begin errs++; $display("FAIL wait_tick_count got %0d want 3", ticks); end
    vec++; if (state !== 2'b10) begin errs++; $display("FAIL wait_state got %b want 10", state); end
    wheel_pulse = 1'b1;
    step();
    wheel_pulse = 1'b0;
    vec++; if (state !== 2'b01) begin errs++; $display("FAIL wait_resume got %b want 01", state); end
    vec++; if (wait_tick !== 1'b0) begin errs++; $display("FAIL wait_resume_tick got %b want 0", wait_tick); end
    // 52 pulses are now counted, so the 48th further pulse reaches 100
    for (int n = 1; n <= 48; n++) begin
      pulse_once(t);
      if (n < 48 && t) early++;
      if (n == 48) begin
        vec++; if (t !== 1'b1) begin errs++; $display("FAIL resume_pulse_counted got %b want 1", t); end
      end
    end
    vec++; if (early != 0) begin errs++; $display("FAIL resume_early_ticks got %0d want 0", early); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    vec++; if (trip_end !== 1'b1) begin errs++; $display("FAIL stop_trip_end got %b want 1", trip_end); end
    vec++; if (state !== 2'b00) begin errs++; $display("FAIL stop_state got %b want 00", state); end
    step();
    vec++; if (trip_end !== 1'b0) begin errs++; $display("FAIL trip_end_width got %b want 0", trip_end); end
  endtask
  task automatic test_stop_on_tick();
    int early = 0;
    logic t;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 99; n++) begin
      pulse_once(t);
      if (t) early++;
    end
    wheel_pulse = 1'b1;
    stop = 1'b1;
    step();
    wheel_pulse = 1'b0;
    stop = 1'b0;
    vec++; if (dist_tick !== 1'b0) begin errs++; $display("FAIL stop_tick_dist got %b want 0", dist_tick); end
    vec++; if (trip_end !== 1'b1) begin errs++; $display("FAIL stop_tick_end got %b want 1", trip_end); end
    vec++; if (state !== 2'b00) begin errs++; $display("FAIL stop_tick_state got %b want 00", state); end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      pulse_once(t);
      if (n < 100 && t) early++;
      if (n == 100) begin
        vec++; if (t !== 1'b1) begin errs++; $display("FAIL restart_tick100 got %b want 1", t); end
      end
    end
    vec++; if (early != 0) begin errs++; $display("FAIL stop_early_ticks got %0d want 0", early); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask
  task automatic test_start_stop();
    logic t;
    start = 1'b1;
    stop = 1'b1;
    step();
    vec++; if (state !== 2'b00) begin errs++; $display("FAIL start_and_stop got %b want 00", state); end
    vec++; if (trip_end !== 1'b0) begin errs++; $display("FAIL start_and_stop_end got %b want 0", trip_end); end
    stop = 1'b0;
    step();
    vec++; if (state !== 2'b01) begin errs++; $display("FAIL start_alone got %b want 01", state); end
    repeat (3) pulse_once(t);
    vec++; if (state !== 2'b01) begin errs++; $display("FAIL start_in_run got %b want 01", state); end
    start = 1'b0;
    rst_n = 1'b0;
    step();
    vec++; if (state !== 2'b00) begin errs++; $display("FAIL midtrip_reset_state got %b want 00", state); end
    vec++; if (trip_end !== 1'b0) begin errs++; $display("FAIL midtrip_reset_end got %b want 0", trip_end); end
    rst_n = 1'b1;
    step();
  endtask
`ifdef TAXI_TICK_CFG_EN
  task automatic test_cfg();
    logic t;
    cfg_we = 1'b1;
    cfg_sel = 2'd0;
    cfg_data = 12'd4;
    step();
    cfg_we = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      pulse_once(t);
      vec++; if (t !== (n % 4 == 0)) begin errs++; $display("FAIL cfg4_p%0d got %b want %b", n, t, (n % 4 == 0)); end
    end
    cfg_we = 1'b1;
    cfg_data = 12'd8;
    step();
    cfg_we = 1'b0;
    for (int n = 9; n <= 12; n++) begin
      pulse_once(t);
      vec++; if (t !== (n == 12)) begin errs++; $display("FAIL cfg_run_write_p%0d got %b want %b", n, t, (n == 12)); end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    cfg_we = 1'b1;
    cfg_data = 12'd0;
    step();
    cfg_we = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      pulse_once(t);
      vec++; if (t !== (n == 4)) begin errs++; $display("FAIL cfg_zero_p%0d got %b want %b", n, t, (n == 4)); end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask
`endif
  initial begin
    test_reset();
    test_distance();
    test_stall_wait();
    test_stop_on_tick();
    test_start_stop();
`ifdef TAXI_TICK_CFG_EN
    test_cfg();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
